top_test_module: RTL and testbench

//  FPGA bring-up top for AES-128 encryption over UART (8N1, LSB first).

---
 rtl/top_test_module.sv | 320 ++++++++++++++++++++++++++++++++
 tb/tb_top_test_module.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/top_test_module.sv
// -----------------------------------------------------------------------------
// top_test_module / aes_encrypt
//
// Purpose: board-level bring-up of an AES-128 encryptor driven over a UART
// (8N1, LSB first). The host sends a 16-byte plaintext block, then a 16-byte
// key block. The ciphertext comes back as 16 frames. The first byte on the
// wire is the most significant byte of each block.
//
// top_test_module ports:
//   clk    in   system clock, rising edge
//   reset  in   asynchronous active-high reset
//   rx     in   UART receive line (idle high, asynchronous to clk)
//   tx     out  UART transmit line (idle high)
//
// aes_encrypt ports:
//   clk, reset          clock / asynchronous active-high reset
//   start               1-cycle pulse, loads plaintext and key
//   plaintext, key      128-bit inputs, byte 0 in bits [127:120]
//   ciphertext          result, valid while done is high
//   done                1-cycle pulse when the 10th round completes
// -----------------------------------------------------------------------------

module aes_encrypt (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] plaintext,
  input  logic [127:0] key,
  output logic [127:0] ciphertext,
  output logic         done
);
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box computed rather than tabulated: inverse is x^254 (0 maps to 0),
  // followed by the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  logic [127:0] state_reg;
  logic [127:0] rk_reg;
  logic [3:0]   round_reg;
  logic [7:0]   rcon_reg;
  logic         busy_reg;
  logic         done_reg;
  logic [127:0] sb;
  logic [127:0] sr;
  logic [127:0] mc;
  logic [31:0]  sub_rot;
  logic [31:0]  w0_next, w1_next, w2_next, w3_next;
  logic [127:0] rk_next;

  // State byte gi sits at row gi%4, column gi/4. ShiftRows pulls the byte
  // from column (col+row)%4 of the same row.
  for (genvar gi = 0; gi < 16; gi++) begin : g_byte
    localparam int ROW = gi % 4;
    localparam int COL = gi / 4;
    localparam int SRC = ROW + 4 * ((COL + ROW) % 4);
    assign sb[127-8*gi -: 8] = sbox(state_reg[127-8*gi -: 8]);
    assign sr[127-8*gi -: 8] = sb[127-8*SRC -: 8];
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_col
    logic [7:0] a0, a1, a2, a3;
    assign a0 = sr[127-32*gi -: 8];
    assign a1 = sr[119-32*gi -: 8];
    assign a2 = sr[111-32*gi -: 8];
    assign a3 = sr[103-32*gi -: 8];
    assign mc[127-32*gi -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    assign mc[119-32*gi -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    assign mc[111-32*gi -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    assign mc[103-32*gi -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
  end

  // Key schedule is computed on the fly, one round key per cycle.
  assign sub_rot = {sbox(rk_reg[23:16]), sbox(rk_reg[15:8]), sbox(rk_reg[7:0]),
                    sbox(rk_reg[31:24])} ^ {rcon_reg, 24'h000000};
  assign w0_next = rk_reg[127:96] ^ sub_rot;
  assign w1_next = rk_reg[95:64] ^ w0_next;
  assign w2_next = rk_reg[63:32] ^ w1_next;
  assign w3_next = rk_reg[31:0] ^ w2_next;
  assign rk_next = {w0_next, w1_next, w2_next, w3_next};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= '0;
      rk_reg    <= '0;
      round_reg <= '0;
      rcon_reg  <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else if (start) begin
      state_reg <= plaintext ^ key;
      rk_reg    <= key;
      round_reg <= 4'd1;
      rcon_reg  <= 8'h01;
      busy_reg  <= 1'b1;
      done_reg  <= 1'b0;
    end else if (busy_reg) begin
      // Final round skips MixColumns.
      state_reg <= (round_reg == 4'd10) ? (sr ^ rk_next) : (mc ^ rk_next);
      rk_reg    <= rk_next;
      rcon_reg  <= xtime(rcon_reg);
      round_reg <= round_reg + 4'd1;
      busy_reg  <= (round_reg != 4'd10);
      done_reg  <= (round_reg == 4'd10);
    end else begin
      done_reg  <= 1'b0;
    end
  end

  assign ciphertext = state_reg;
  assign done       = done_reg;
endmodule

module top_test_module #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUDRATE = 115_200,
  parameter int LENGTH   = 8,
  parameter int WIDTH    = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic rx,
  output logic tx
);
  localparam int CLKS_PER_BIT = CLK_FREQ / BAUDRATE;
  localparam int NBYTES       = WIDTH * WIDTH;
  localparam int CLK_W        = $clog2(CLKS_PER_BIT);
  localparam int CNT_W        = $clog2(NBYTES);
  localparam int BIT_W        = $clog2(LENGTH);
  localparam int FRM_W        = $clog2(LENGTH + 2);
  localparam logic [CLK_W-1:0] BIT_LAST   = CLK_W'(CLKS_PER_BIT - 1);
  localparam logic [CLK_W-1:0] HALF_LAST  = CLK_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] LAST_BYTE  = CNT_W'(NBYTES - 1);
  localparam logic [BIT_W-1:0] LAST_DBIT  = BIT_W'(LENGTH - 1);
  localparam logic [FRM_W-1:0] FRAME_LAST = FRM_W'(LENGTH + 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {C_LOAD_PT, C_LOAD_KEY, C_START_AES, C_WAIT_AES, C_SEND} c_state_t;

  // ---------------- rx synchronizer ----------------
  logic rx_meta_reg, rx_sync_reg, rx_prev_reg;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_reg <= 1'b1;
      rx_sync_reg <= 1'b1;
      rx_prev_reg <= 1'b1;
    end else begin
      // Anything that is not a solid 0 (including an undriven pin) reads as idle.
      rx_meta_reg <= (rx !== 1'b0);
      rx_sync_reg <= rx_meta_reg;
      rx_prev_reg <= rx_sync_reg;
    end
  end

  // ---------------- UART receiver ----------------
  rx_state_t         rx_state_reg, rx_state_next;
  logic [CLK_W-1:0]  rx_clk_reg;
  logic [BIT_W-1:0]  rx_bit_reg;
  logic [LENGTH-1:0] rx_shift_reg;
  logic              rx_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rx_state_reg <= RX_IDLE;
    else       rx_state_reg <= rx_state_next;
  end

  always_comb begin
    rx_state_next = rx_state_reg;
    case (rx_state_reg)
      RX_IDLE:  if (rx_prev_reg && !rx_sync_reg) rx_state_next = RX_START;
      RX_START: if (rx_clk_reg == HALF_LAST) rx_state_next = rx_sync_reg ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_clk_reg == BIT_LAST && rx_bit_reg == LAST_DBIT) rx_state_next = RX_STOP;
      RX_STOP:  if (rx_clk_reg == BIT_LAST) rx_state_next = RX_IDLE;
      default:  rx_state_next = RX_IDLE;
    endcase
  end

  // A byte with a low stop bit is silently dropped.
  always_comb begin
    rx_valid = (rx_state_reg == RX_STOP) && (rx_clk_reg == BIT_LAST) && rx_sync_reg;
  end

  // Counter restarts on every state change, so after the half-bit start
  // check each later sample lands mid-bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_clk_reg   <= '0;
      rx_bit_reg   <= '0;
      rx_shift_reg <= '0;
    end else begin
      if (rx_state_reg == RX_IDLE || rx_state_next != rx_state_reg || rx_clk_reg == BIT_LAST)
        rx_clk_reg <= '0;
      else
        rx_clk_reg <= rx_clk_reg + 1'b1;
      if (rx_state_reg == RX_START) begin
        rx_bit_reg <= '0;
      end else if (rx_state_reg == RX_DATA && rx_clk_reg == BIT_LAST) begin
        rx_bit_reg   <= rx_bit_reg + 1'b1;
        rx_shift_reg <= {rx_sync_reg, rx_shift_reg[LENGTH-1:1]};
      end
    end
  end

  // ---------------- block collector / transmitter ----------------
  c_state_t                     c_state_reg, c_state_next;
  logic [CNT_W-1:0]             byte_cnt_reg, byte_cnt_inc, byte_sel;
  logic [NBYTES-1:0][LENGTH-1:0] pt_reg, key_reg, ct_reg;
  logic [CLK_W-1:0]             tx_clk_reg;
  logic [FRM_W-1:0]             tx_bit_reg;
  logic                         tx_reg, tx_next;
  logic [LENGTH+1:0]            tx_frame;
  logic                         aes_start, aes_done;
  logic [127:0]                 aes_ct;

  // Byte 0 of a block lands in the top slot of the packed array.
  assign byte_sel     = LAST_BYTE - byte_cnt_reg;
  assign byte_cnt_inc = (byte_cnt_reg == LAST_BYTE) ? '0 : byte_cnt_reg + 1'b1;
  assign tx_frame     = {1'b1, ct_reg[byte_sel], 1'b0};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) c_state_reg <= C_LOAD_PT;
    else       c_state_reg <= c_state_next;
  end

  always_comb begin
    c_state_next = c_state_reg;
    case (c_state_reg)
      C_LOAD_PT:   if (rx_valid && byte_cnt_reg == LAST_BYTE) c_state_next = C_LOAD_KEY;
      C_LOAD_KEY:  if (rx_valid && byte_cnt_reg == LAST_BYTE) c_state_next = C_START_AES;
      C_START_AES: c_state_next = C_WAIT_AES;
      C_WAIT_AES:  if (aes_done) c_state_next = C_SEND;
      C_SEND:      if (tx_clk_reg == BIT_LAST && tx_bit_reg == FRAME_LAST && byte_cnt_reg == LAST_BYTE)
                     c_state_next = C_LOAD_PT;
      default:     c_state_next = C_LOAD_PT;
    endcase
  end

  always_comb begin
    aes_start = (c_state_reg == C_START_AES);
    tx_next   = 1'b1;
    if (c_state_reg == C_SEND) tx_next = tx_frame[tx_bit_reg];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_cnt_reg <= '0;
      pt_reg       <= '0;
      key_reg      <= '0;
      ct_reg       <= '0;
      tx_clk_reg   <= '0;
      tx_bit_reg   <= '0;
      tx_reg       <= 1'b1;
    end else begin
      tx_reg <= tx_next;
      case (c_state_reg)
        C_LOAD_PT: if (rx_valid) begin
          pt_reg[byte_sel] <= rx_shift_reg;
          byte_cnt_reg     <= byte_cnt_inc;
        end
        C_LOAD_KEY: if (rx_valid) begin
          key_reg[byte_sel] <= rx_shift_reg;
          byte_cnt_reg      <= byte_cnt_inc;
        end
        C_WAIT_AES: if (aes_done) ct_reg <= aes_ct;
        C_SEND: begin
          // The byte counter doubles as the transmit byte index.
          if (tx_clk_reg == BIT_LAST) begin
            tx_clk_reg <= '0;
            if (tx_bit_reg == FRAME_LAST) begin
              tx_bit_reg   <= '0;
              byte_cnt_reg <= byte_cnt_inc;
            end else begin
              tx_bit_reg <= tx_bit_reg + 1'b1;
            end
          end else begin
            tx_clk_reg <= tx_clk_reg + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  aes_encrypt u_aes (
    .clk        (clk),
    .reset      (reset),
    .start      (aes_start),
    .plaintext  (pt_reg),
    .key        (key_reg),
    .ciphertext (aes_ct),
    .done       (aes_done)
  );

  assign tx = tx_reg;
endmodule

// File: tb/tb_top_test_module.sv
// -----------------------------------------------------------------------------
// tb_top_test_module: directed bench for the UART AES-128 bring-up top.
// Runs the UART at 24 clocks per bit so a full session stays short; the
// expected ciphertexts are published AES-128 known-answer vectors.
// -----------------------------------------------------------------------------
module tb_top_test_module;
  localparam int CPB = 24;
  localparam int TMO = 40 * 10 * CPB;
  localparam logic [127:0] V1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] V1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] V1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] V2_PT  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] V2_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] V2_CT  = 128'h3925841d02dc09fbdc118597196a0b32;

  logic clk = 1'b0;
  logic reset;
  logic rx;
  logic tx;
  int   n_tests = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   done_cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (dut.aes_done) done_cyc <= cyc;

  top_test_module #(
    .CLK_FREQ (100_000_000),
    .BAUDRATE (4_166_666),
    .LENGTH   (8),
    .WIDTH    (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .rx    (rx),
    .tx    (tx)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    logic [9:0] frame;
    frame = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = frame[i];
      repeat (CPB) @(negedge clk);
    end
  endtask

  task automatic send_block(input logic [127:0] blk);
    for (int i = 0; i < 16; i++) send_byte(blk[127-8*i -: 8], 1'b1);
  endtask

  // Waits for the first response frame, then pushes bytes the DUT must ignore.
  task automatic send_junk();
    int t;
    t = 0;
    while (tx !== 1'b0 && t < TMO) begin
      @(negedge clk);
      t++;
    end
    if (t < TMO) begin
      send_byte(8'hff, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h3c, 1'b1);
    end
  endtask

  task automatic recv_block(output logic [127:0] blk, output int first_s, output int last_s,
                            output bit ok);
    int t;
    logic [7:0] b;
    blk = '0;
    first_s = 0;
    last_s = 0;
    ok = 1'b1;
    for (int k = 0; k < 16; k++) begin
      t = 0;
      while (tx !== 1'b0 && t < TMO) begin
        @(negedge clk);
        t++;
      end
      if (t >= TMO) begin
        ok = 1'b0;
        return;
      end
      if (k == 0) first_s = cyc;
      last_s = cyc;
      repeat (CPB / 2) @(negedge clk);
      if (tx !== 1'b0) ok = 1'b0;
      for (int j = 0; j < 8; j++) begin
        repeat (CPB) @(negedge clk);
        b[j] = tx;
      end
      repeat (CPB) @(negedge clk);
      if (tx !== 1'b1) ok = 1'b0;
      blk[127-8*k -: 8] = b;
    end
  endtask

  task automatic run_vector(input string tag, input logic [127:0] pt, input logic [127:0] key,
                            input logic [127:0] exp, input bit junk);
    logic [127:0] ct;
    bit ok;
    bit lat_ok;
    int first_s;
    int last_s;
    fork
      begin
        send_block(pt);
        send_block(key);
        if (junk) send_junk();
      end
      recv_block(ct, first_s, last_s, ok);
    join
    lat_ok = ((first_s - done_cyc) >= 1) && ((first_s - done_cyc) <= 2);
    $display("[TB] %s: pt %032h key %032h -> ct %032h", tag, pt, key, ct);
    check({tag, "_ct"}, ct, exp);
    check({tag, "_frames"}, 128'(ok), 128'(1));
    check({tag, "_spacing"}, 128'(last_s - first_s), 128'(150 * CPB));
    check({tag, "_latency"}, 128'(lat_ok), 128'(1));
    repeat (CPB) @(negedge clk);
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int tx_low;
    logic [127:0] v;
    rx = 1'b1;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_tx", 128'(tx), 128'(1));
    check("reset_cnt", 128'(dut.byte_cnt_reg), 128'(0));
    check("reset_pt", 128'(dut.pt_reg), 128'(0));
    check("reset_key", 128'(dut.key_reg), 128'(0));
    check("reset_ct", 128'(dut.ct_reg), 128'(0));
    reset = 1'b0;
    repeat (2 * CPB) @(negedge clk);

    // Single byte, then idle: stored, no transmission.
    send_byte(8'h55, 1'b1);
    tx_low = 0;
    for (int i = 0; i < 20 * CPB; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) tx_low++;
    end
    v = dut.pt_reg;
    $display("[TB] single byte 55: pt %032h cnt %0d", v, dut.byte_cnt_reg);
    check("single_tx_idle", 128'(tx_low), 128'(0));
    check("single_pt_top", 128'(v[127:120]), 128'(8'h55));
    check("single_cnt", 128'(dut.byte_cnt_reg), 128'(1));

    // 100 ns low glitch, shorter than half a bit.
    rx = 1'b0;
    repeat (10) @(negedge clk);
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    v = dut.pt_reg;
    $display("[TB] glitch: cnt %0d", dut.byte_cnt_reg);
    check("glitch_cnt", 128'(dut.byte_cnt_reg), 128'(1));
    check("glitch_pt_top", 128'(v[127:120]), 128'(8'h55));

    // Clear the partial block.
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2 * CPB) @(negedge clk);

    run_vector("fips_c1", V1_PT, V1_KEY, V1_CT, 1'b0);

    // Framing error: byte dropped, next full block still correct.
    send_byte(8'ha5, 1'b0);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    $display("[TB] framing error byte a5: cnt %0d", dut.byte_cnt_reg);
    check("framing_cnt", 128'(dut.byte_cnt_reg), 128'(0));
    run_vector("fips_b", V2_PT, V2_KEY, V2_CT, 1'b0);

    // Reset part-way into the 21st byte.
    send_block(V1_PT);
    for (int i = 0; i < 4; i++) send_byte(V1_KEY[127-8*i -: 8], 1'b1);
    check("partial_cnt", 128'(dut.byte_cnt_reg), 128'(4));
    rx = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    reset = 1'b1;
    rx = 1'b1;
    @(negedge clk);
    $display("[TB] reset after 20 bytes: tx %0b cnt %0d", tx, dut.byte_cnt_reg);
    check("midreset_tx", 128'(tx), 128'(1));
    check("midreset_cnt", 128'(dut.byte_cnt_reg), 128'(0));
    check("midreset_pt", 128'(dut.pt_reg), 128'(0));
    repeat (4) @(negedge clk);
    reset = 1'b0;
    repeat (2 * CPB) @(negedge clk);

    // Back-to-back sessions; bytes arriving during the response are ignored.
    run_vector("fips_c1_after_reset", V1_PT, V1_KEY, V1_CT, 1'b1);
    run_vector("fips_c1_back_to_back", V1_PT, V1_KEY, V1_CT, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
